// File: rtl/branch_seq.sv
// ---------------------------------------------------------------------------
// branch_seq -- branch / jump resolution sequencer
//
// Purpose
//   Accepts one branch or jump request at a time, resolves its condition and
//   target, and then sequences the front-end reaction:
//     * illegal encoding   -> exc_illegal + br_done (not counted)
//     * not taken          -> br_done two cycles after the request
//     * taken, misaligned  -> exc_misalign + br_done, no redirect
//     * taken, aligned     -> redirect handshake, then a FLUSH_CYC-cycle
//                             flush pulse with br_done in its last cycle
//   Every output is driven straight from a flop.
//
// Parameters
//   XLEN      datapath width
//   FLUSH_CYC flush pulse length in cycles (1..15)
//   CNT_W     statistics counter width
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   br_valid / br_ready        request handshake (ready only while idle)
//   br_type                    00 B-type, 01 JAL, 10 JALR, 11 reserved
//   funct3                     B-type condition select
//   rs1_data, rs2_data         comparison operands (rs1 is the JALR base)
//   pc, imm                    instruction address, sign-extended immediate
//   redirect_valid/_pc/_ack    fetch redirect handshake
//   flush                      kill younger instructions
//   br_done, br_taken          completion pulse and resolved outcome
//   link_data                  pc+4 for JAL/JALR, 0 for B-type
//   exc_misalign, exc_illegal  one-cycle exception pulses
//   br_cnt, taken_cnt          resolved / taken request counters (wrapping)
// ---------------------------------------------------------------------------
module branch_seq #(
  parameter int XLEN      = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_type,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             br_done,
  output logic             br_taken,
  output logic [XLEN-1:0]  link_data,
  output logic             exc_misalign,
  output logic             exc_illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Request encodings
  localparam logic [1:0] TYPE_B    = 2'b00;
  localparam logic [1:0] TYPE_JAL  = 2'b01;
  localparam logic [1:0] TYPE_JALR = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Value loaded into the flush down-counter on redirect acknowledge; the
  // counter then holds the number of flush cycles still to follow.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2,
    FLUSH = 2'd3
  } stateT;

  stateT            stateReg;
  logic [3:0]       flushCntReg;

  // Request captured at acceptance; EVAL works only from these copies so the
  // upstream stage may change its inputs freely after the handshake.
  logic [1:0]       brTypeReg;
  logic [2:0]       funct3Reg;
  logic [XLEN-1:0]  rs1Reg;
  logic [XLEN-1:0]  rs2Reg;
  logic [XLEN-1:0]  pcReg;
  logic [XLEN-1:0]  immReg;

  // -------------------------------------------------------------------------
  // Resolution datapath (consumed only in EVAL)
  // -------------------------------------------------------------------------
  logic             opEq;
  logic             opLtSigned;
  logic             opLtUnsigned;
  logic             isJump;
  logic             evalIllegal;
  logic             evalTaken;
  logic             evalMisalign;
  logic [XLEN-1:0]  seqTarget;
  logic [XLEN-1:0]  jalrSum;
  logic [XLEN-1:0]  evalTarget;
  logic [XLEN-1:0]  evalLink;

  always_comb begin
    opEq         = (rs1Reg == rs2Reg);
    opLtSigned   = ($signed(rs1Reg) < $signed(rs2Reg));
    opLtUnsigned = (rs1Reg < rs2Reg);

    isJump = (brTypeReg == TYPE_JAL) || (brTypeReg == TYPE_JALR);

    // funct3 010/011 are the only unused B-type encodings.
    evalIllegal = (brTypeReg == 2'b11) ||
                  ((brTypeReg == TYPE_B) && (funct3Reg[2:1] == 2'b01));

    evalTaken = 1'b0;
    if (isJump) begin
      evalTaken = 1'b1;
    end else if (brTypeReg == TYPE_B) begin
      case (funct3Reg)
        F3_BEQ:  evalTaken = opEq;
        F3_BNE:  evalTaken = !opEq;
        F3_BLT:  evalTaken = opLtSigned;
        F3_BGE:  evalTaken = !opLtSigned;
        F3_BLTU: evalTaken = opLtUnsigned;
        F3_BGEU: evalTaken = !opLtUnsigned;
        default: evalTaken = 1'b0;
      endcase
    end

    // Both sums wrap modulo 2^XLEN; JALR clears bit 0 of its sum.
    seqTarget  = pcReg + immReg;
    jalrSum    = rs1Reg + immReg;
    evalTarget = (brTypeReg == TYPE_JALR) ? {jalrSum[XLEN-1:1], 1'b0} : seqTarget;

    evalMisalign = evalTaken && (evalTarget[1:0] != 2'b00);
    evalLink     = isJump ? (pcReg + XLEN'(4)) : '0;
  end

  // -------------------------------------------------------------------------
  // Sequencer with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg       <= IDLE;
      br_ready       <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      br_done        <= 1'b0;
      br_taken       <= 1'b0;
      link_data      <= '0;
      exc_misalign   <= 1'b0;
      exc_illegal    <= 1'b0;
      br_cnt         <= '0;
      taken_cnt      <= '0;
      flushCntReg    <= '0;
      brTypeReg      <= '0;
      funct3Reg      <= '0;
      rs1Reg         <= '0;
      rs2Reg         <= '0;
      pcReg          <= '0;
      immReg         <= '0;
    end else begin
      // Pulse outputs default low so none can last more than one cycle.
      br_done      <= 1'b0;
      br_taken     <= 1'b0;
      exc_misalign <= 1'b0;
      exc_illegal  <= 1'b0;

      case (stateReg)
        IDLE: begin
          // br_ready is high throughout IDLE, so br_valid alone accepts.
          if (br_valid) begin
            brTypeReg <= br_type;
            funct3Reg <= funct3;
            rs1Reg    <= rs1_data;
            rs2Reg    <= rs2_data;
            pcReg     <= pc;
            immReg    <= imm;
            br_ready  <= 1'b0;
            stateReg  <= EVAL;
          end
        end

        EVAL: begin
          if (evalIllegal) begin
            exc_illegal <= 1'b1;
            br_done     <= 1'b1;
            link_data   <= '0;
            br_ready    <= 1'b1;
            stateReg    <= IDLE;
          end else begin
            // The resolved target is published for every legal request, so
            // a misaligned jump still reports where it would have gone.
            // redirect_pc then stays put until the next request resolves.
            redirect_pc <= evalTarget;
            link_data   <= evalLink;
            if (!evalTaken || evalMisalign) begin
              exc_misalign <= evalMisalign;
              br_done      <= 1'b1;
              br_cnt       <= br_cnt + CNT_W'(1);
              br_ready     <= 1'b1;
              stateReg     <= IDLE;
            end else begin
              redirect_valid <= 1'b1;
              stateReg       <= REDIR;
            end
          end
        end

        REDIR: begin
          if (redirect_ack) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            flushCntReg    <= FLUSH_LAST;
            stateReg       <= FLUSH;
            // A one-cycle flush is also the last flush cycle.
            if (FLUSH_CYC == 1) begin
              br_done   <= 1'b1;
              br_taken  <= 1'b1;
              br_cnt    <= br_cnt + CNT_W'(1);
              taken_cnt <= taken_cnt + CNT_W'(1);
            end
          end
        end

        FLUSH: begin
          if (flushCntReg == 4'd0) begin
            flush    <= 1'b0;
            br_ready <= 1'b1;
            stateReg <= IDLE;
          end else begin
            flushCntReg <= flushCntReg - 4'd1;
            // Entering the final flush cycle: completion rides along with it.
            if (flushCntReg == 4'd1) begin
              br_done   <= 1'b1;
              br_taken  <= 1'b1;
              br_cnt    <= br_cnt + CNT_W'(1);
              taken_cnt <= taken_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          br_ready       <= 1'b1;
          stateReg       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width.
REQ-002 The block SHALL have parameter FLUSH_CYC, default 2, flush pulse length in cycles (legal range 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 br_valid  input  1  branch/jump request present.
REQ-007 br_ready  output  1  block can accept a request.
REQ-008 br_type  input  2  00 B-type branch, 01 JAL, 10 JALR, 11 reserved.
REQ-009 funct3  input  3  B-type condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 rs1_data, rs2_data  input  XLEN each  comparison operands.
REQ-011 pc, imm  input  XLEN each  instruction address and sign-extended immediate.
REQ-012 redirect_valid  output  1  fetch redirect request.
REQ-013 redirect_pc  output  XLEN  redirect target.
REQ-014 redirect_ack  input  1  fetch accepted redirect.
REQ-015 flush  output  1  kill younger instructions.
REQ-016 br_done  output  1  one-cycle completion pulse.
REQ-017 br_taken  output  1  resolved outcome, valid with br_done.
REQ-018 link_data  output  XLEN  pc+4 for JAL/JALR, valid with br_done; 0 for B-type.
REQ-019 exc_misalign, exc_illegal  output  1 each  one-cycle exception pulses.
REQ-020 br_cnt, taken_cnt  output  CNT_W each  resolved-branch and taken-branch counters.

Function
REQ-021 The FSM SHALL have states IDLE, EVAL, REDIR, FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, br_valid&&br_ready SHALL capture br_type, funct3, rs1_data, rs2_data, pc, imm and move to EVAL; br_valid outside IDLE is ignored.
REQ-023 In EVAL (exactly one cycle) the condition SHALL be: BEQ eq, BNE !eq, BLT/BGE signed lt/ge, BLTU/BGEU unsigned lt/ge; JAL/JALR always taken.
REQ-024 Target SHALL be pc+imm for B-type/JAL and (rs1_data+imm)&~1 for JALR, modulo 2^XLEN (wrap-around, no overflow flag).
REQ-025 funct3 010/011 with br_type 00, or br_type 11, SHALL pulse exc_illegal and br_done with br_taken=0 at EVAL exit, go to IDLE, and not increment counters.
REQ-026 Taken with target[1:0]!=0 SHALL pulse exc_misalign and br_done with br_taken=0, no redirect, then IDLE; br_cnt increments, taken_cnt does not.
REQ-027 Not-taken SHALL pulse br_done with br_taken=0 at EVAL exit and return to IDLE (request-to-done latency 2 cycles).
REQ-028 Taken and aligned SHALL go to REDIR with redirect_valid=1 and redirect_pc stable until the cycle redirect_ack is sampled high.
REQ-029 An ack sampled in the first REDIR cycle SHALL be legal; redirect_ack while not in REDIR SHALL be ignored.
REQ-030 On ack, FSM SHALL enter FLUSH, assert flush for exactly FLUSH_CYC consecutive cycles, pulse br_done with br_taken=1 in the last flush cycle, then return to IDLE.
REQ-031 br_cnt SHALL increment once per br_done of a legal request; taken_cnt once per br_done with br_taken=1; both wrap at 2^CNT_W.
REQ-032 link_data SHALL equal captured pc+4 (mod 2^XLEN) for JAL/JALR, including on misaligned completion.
REQ-033 All outputs SHALL be registered; br_done, exc_* SHALL never be high for more than one consecutive cycle.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and drive redirect_valid, flush, br_done, br_taken, exc_misalign, exc_illegal, redirect_pc, link_data, br_cnt, taken_cnt to 0, independent of clk.
REQ-035 Reset asserted in REDIR or FLUSH SHALL abandon the request with no br_done; br_ready SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-036 BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20 -> redirect_pc=0x120; ack after 3 cycles -> flush high 2 cycles, br_done/br_taken=1, taken_cnt=1.
REQ-037 BLT rs1=0xFFFFFFFF, rs2=1 taken; BLTU same operands not taken -> br_done with br_taken=0 two cycles after request, br_cnt=2, taken_cnt=1.
REQ-038 JALR rs1=0x203, imm=0 -> redirect_pc=0x202, link_data=pc+4; JAL pc=0x100, imm=0x6 -> exc_misalign pulse, no redirect_valid.
REQ-039 B-type funct3=010 -> exc_illegal pulse, br_taken=0, counters unchanged; br_valid held during REDIR -> not accepted until IDLE.
REQ-040 rst_n low during second FLUSH cycle -> flush, outputs, counters 0 same cycle; no br_done; new BNE rs1=1, rs2=2 accepted after reset resolves taken normally.
REQ-041 pc=0xFFFFFFFC, imm=0x8, BEQ taken -> redirect_pc=0x4 (wrap-around).
